iagc_init_seq_fsm: RTL and testbench
====================================

Name: iagc_init_seq_fsm

Overview:
- Top-level IAGC control FSM, generalised from fixed ADC+DAC init to NUM_PERIPH peripheral channels.
- Issues one-cycle init-start pulses to each peripheral and collects their init-done levels. Applies a per-attempt timeout with bounded retries, then reports IDLE, RUN or ERROR on o_status.
- Status codes 0/1/2 (RESET/INIT/IDLE) keep their existing meaning, so current o_status consumers are unaffected.

Parameters:
- STATUS_SIZE, 4, width of o_status (minimum 3).
- NUM_PERIPH, 2, number of peripheral init channels (minimum 1).
- TIMEOUT_CYCLES, 1024, cycles allowed per wait attempt (minimum 2).
- MAX_RETRIES, 3, retries after the first timeout before ERROR (0 means the first timeout goes to ERROR).
- SEQUENTIAL, 0, init mode: 0 = all channels in parallel, 1 = one channel at a time in index order.

Ports:
- i_clock  in  1  system clock; all flops on the rising edge.
- i_nReset  in  1  asynchronous, active-low reset.
- i_initDone  in  NUM_PERIPH  per-channel init-done level from the peripheral.
- i_start  in  1  request IDLE->RUN.
- i_stop  in  1  request RUN->IDLE.
- i_clearError  in  1  leave ERROR and restart the init sequence.
- o_initStart  out  NUM_PERIPH  one-cycle start pulse per channel.
- o_status  out  STATUS_SIZE  state code: RESET=0, INIT=1, IDLE=2, RUN=3, ERROR=4.
- o_running  out  1  high while in RUN.
- o_error  out  1  high while in ERROR.
- o_failMask  out  NUM_PERIPH  channels not done at entry to ERROR.
- o_retryCount  out  $clog2(MAX_RETRIES+1)  number of timeouts in the current sequence.

Behaviour:
- Reset:
  - Asynchronous assertion forces state RESET and clears the done-latch, timeout counter, retry count, channel index and fail mask.
  - Every output reads 0 during reset, including o_initStart.
  - Reset may assert at any point (mid-INIT, RUN, ERROR); no partial state survives.
- Internal states: RESET, INIT_START, INIT_WAIT, IDLE, RUN, ERROR.
  - o_status = 1 in both INIT_START and INIT_WAIT; the other states use their own codes.
  - All outputs are Moore outputs decoded from registers; no combinational path from inputs.
- Done-latch (NUM_PERIPH bits):
  - Bit k sets on any cycle with i_initDone[k]=1 while in INIT_WAIT.
  - Clears on RESET->INIT_START and on ERROR->INIT_START.
  - Completion check uses (done-latch OR i_initDone).
- RESET: always -> INIT_START on the next edge.
- INIT_START: lasts exactly one cycle, then -> INIT_WAIT.
  - o_initStart in parallel mode: the bits of channels not yet done.
  - o_initStart in sequential mode: the one-hot bit of the current index.
  - Timeout counter loads 0.
- INIT_WAIT: counter increments each cycle.
  - Complete = all channels done (parallel), or channel[idx] done (sequential).
  - Complete, parallel -> IDLE.
  - Complete, sequential: idx == NUM_PERIPH-1 -> IDLE; otherwise idx+1 -> INIT_START.
  - Timeout when counter == TIMEOUT_CYCLES-1 and not complete.
  - Completion has priority over timeout in the same cycle.
  - On timeout with retryCount < MAX_RETRIES: retryCount+1 -> INIT_START. Sequential mode keeps the same idx, so only the pending channels are re-pulsed.
  - On timeout with retryCount == MAX_RETRIES: o_failMask <= ~(done-latch | i_initDone), sampled that cycle -> ERROR.
- Retry scope: retryCount counts over the whole sequence; it is not reset per channel. It saturates by construction and never wraps.
- IDLE: i_start -> RUN; otherwise stay.
- RUN: i_stop -> IDLE; otherwise stay. i_start is ignored in RUN.
  - In IDLE, simultaneous i_start and i_stop: i_stop wins, stay in IDLE.
- ERROR: o_error=1 and o_failMask holds its value.
  - i_clearError -> INIT_START with retryCount=0, idx=0, done-latch cleared, o_failMask cleared.
- Ignored inputs:
  - i_clearError outside ERROR.
  - i_start and i_stop outside IDLE and RUN.
  - i_initDone outside INIT_WAIT.
- Unreachable state encodings recover to RESET.
- Counter width: $clog2(TIMEOUT_CYCLES); it never exceeds TIMEOUT_CYCLES-1.

Test Plan:
Bench parameters: NUM_PERIPH=2, TIMEOUT_CYCLES=8, MAX_RETRIES=1 unless stated.
1. Reset release, i_initDone=2'b11 from cycle 0 -> o_status 0, 1 (o_initStart=2'b11 for one cycle), 1, 2. o_retryCount=0.
2. Parallel mode; ch0 done, ch1 silent until after the first timeout, then ch1 done -> timeout after 8 wait cycles, o_retryCount=1, o_initStart=2'b10 pulse, then IDLE (status 2).
3. ch1 never done -> two timeouts, o_status=4, o_error=1, o_failMask=2'b10. Then pulse i_clearError -> o_initStart=2'b11, o_retryCount=0, o_failMask=0.
4. SEQUENTIAL=1; ch0 done 3 cycles after its pulse, ch1 done 2 cycles after its pulse -> pulses 2'b01 then 2'b10 (never both), then IDLE.
5. In IDLE: i_start -> RUN with o_running=1; i_start and i_stop together in IDLE -> stay IDLE; i_stop in RUN -> IDLE next cycle.
6. Assert i_nReset low mid-INIT_WAIT, between clock edges -> all outputs 0 immediately. After release, the sequence restarts from RESET with a fresh pulse of 2'b11.

Source files
------------

// File: rtl/iagc_init_seq_fsm_if.sv
// Signal bundle between the IAGC init sequencer and its environment.
// master: the sequencer itself (consumes peripheral/host requests, drives status).
// slave:  the environment (peripherals and host controller).
interface iagc_init_seq_fsm_if #(
  parameter int STATUS_SIZE = 4,
  parameter int NUM_PERIPH  = 2,
  parameter int MAX_RETRIES = 3
);
  // A zero-retry build still needs a one-bit counter port.
  localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  logic [NUM_PERIPH-1:0]  i_initDone;
  logic                   i_start;
  logic                   i_stop;
  logic                   i_clearError;
  logic [NUM_PERIPH-1:0]  o_initStart;
  logic [STATUS_SIZE-1:0] o_status;
  logic                   o_running;
  logic                   o_error;
  logic [NUM_PERIPH-1:0]  o_failMask;
  logic [RETRY_W-1:0]     o_retryCount;

  modport master (
    input  i_initDone, i_start, i_stop, i_clearError,
    output o_initStart, o_status, o_running, o_error, o_failMask, o_retryCount
  );

  modport slave (
    output i_initDone, i_start, i_stop, i_clearError,
    input  o_initStart, o_status, o_running, o_error, o_failMask, o_retryCount
  );
endinterface

// File: rtl/iagc_init_seq_fsm.sv
// IAGC top-level control FSM.
// Pulses init-start to NUM_PERIPH peripheral channels (all at once or one at a
// time), collects their init-done levels, retries on timeout, and reports
// RESET/INIT/IDLE/RUN/ERROR on o_status. All outputs decode from registers.
module iagc_init_seq_fsm #(
  parameter int STATUS_SIZE    = 4,
  parameter int NUM_PERIPH     = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRIES    = 3,
  parameter int SEQUENTIAL     = 0
) (
  input logic                 i_clock,
  input logic                 i_nReset,
  iagc_init_seq_fsm_if.master bus
);

  localparam int CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam int IDX_W   = (NUM_PERIPH < 2) ? 1 : $clog2(NUM_PERIPH);

  // Status codes seen by existing o_status consumers; 0..2 must not move.
  localparam logic [STATUS_SIZE-1:0] CODE_RESET = STATUS_SIZE'(0);
  localparam logic [STATUS_SIZE-1:0] CODE_INIT  = STATUS_SIZE'(1);
  localparam logic [STATUS_SIZE-1:0] CODE_IDLE  = STATUS_SIZE'(2);
  localparam logic [STATUS_SIZE-1:0] CODE_RUN   = STATUS_SIZE'(3);
  localparam logic [STATUS_SIZE-1:0] CODE_ERROR = STATUS_SIZE'(4);

  typedef enum logic [2:0] {
    ST_RESET      = 3'd0,
    ST_INIT_START = 3'd1,
    ST_INIT_WAIT  = 3'd2,
    ST_IDLE       = 3'd3,
    ST_RUN        = 3'd4,
    ST_ERROR      = 3'd5
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [NUM_PERIPH-1:0] done_latch;
  logic [CNT_W-1:0]      tmo_cnt;
  logic [RETRY_W-1:0]    retry_cnt;
  logic [IDX_W-1:0]      idx;
  logic [NUM_PERIPH-1:0] fail_mask;

  // Decoded conditions shared by the next-state logic and the datapath.
  logic [NUM_PERIPH-1:0] seen;
  logic                  in_wait;
  logic                  complete;
  logic                  timeout;
  logic                  last_idx;
  logic                  retry_left;
  logic                  restart;
  logic                  seq_advance;
  logic                  do_retry;
  logic                  do_fail;

  // Moore output values before they are placed on the bus.
  logic [STATUS_SIZE-1:0] status;
  logic [NUM_PERIPH-1:0]  init_start;
  logic                   running;
  logic                   error;

  // A channel counts as done if it was latched earlier or is high right now.
  assign seen       = done_latch | bus.i_initDone;
  assign in_wait    = (state == ST_INIT_WAIT);
  assign complete   = (SEQUENTIAL != 0) ? seen[idx] : (&seen);
  assign timeout    = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign last_idx   = (idx == IDX_W'(NUM_PERIPH - 1));
  assign retry_left = (retry_cnt < RETRY_W'(MAX_RETRIES));

  // Both ways into a fresh sequence wipe the per-sequence bookkeeping.
  assign restart     = (state == ST_RESET) || ((state == ST_ERROR) && bus.i_clearError);
  // Completion beats timeout, so timeout events are qualified with !complete.
  assign seq_advance = in_wait && complete && (SEQUENTIAL != 0) && !last_idx;
  assign do_retry    = in_wait && !complete && timeout && retry_left;
  assign do_fail     = in_wait && !complete && timeout && !retry_left;

  // State register.
  always_ff @(posedge i_clock or negedge i_nReset) begin
    if (!i_nReset) begin
      state <= ST_RESET;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples the pre-edge values regardless of block evaluation order.
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is
    // inferred from an incomplete if/case.
    state_next = state;
    unique case (state)
      ST_RESET:      state_next = ST_INIT_START;
      ST_INIT_START: state_next = ST_INIT_WAIT;
      ST_INIT_WAIT: begin
        if (complete) begin
          if ((SEQUENTIAL == 0) || last_idx) state_next = ST_IDLE;
          else                               state_next = ST_INIT_START;
        end else if (timeout) begin
          state_next = retry_left ? ST_INIT_START : ST_ERROR;
        end
      end
      // Stop wins over a simultaneous start while idle.
      ST_IDLE:  if (bus.i_start && !bus.i_stop) state_next = ST_RUN;
      ST_RUN:   if (bus.i_stop)                 state_next = ST_IDLE;
      ST_ERROR: if (bus.i_clearError)           state_next = ST_INIT_START;
      default:  state_next = ST_RESET;
    endcase
  end

  // Done-latch: records channels that reported done while we were waiting.
  always_ff @(posedge i_clock or negedge i_nReset) begin
    if (!i_nReset) begin
      done_latch <= '0;
    end else if (restart) begin
      done_latch <= '0;
    end else if (in_wait) begin
      done_latch <= done_latch | bus.i_initDone;
    end
  end

  // Per-attempt timeout counter; holds at its terminal value, never wraps.
  always_ff @(posedge i_clock or negedge i_nReset) begin
    if (!i_nReset) begin
      tmo_cnt <= '0;
    end else if (state == ST_INIT_START) begin
      tmo_cnt <= '0;
    end else if (in_wait && !timeout) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  // Retry count spans the whole sequence; ERROR is taken before it could pass MAX_RETRIES.
  always_ff @(posedge i_clock or negedge i_nReset) begin
    if (!i_nReset) begin
      retry_cnt <= '0;
    end else if (restart) begin
      retry_cnt <= '0;
    end else if (do_retry) begin
      retry_cnt <= retry_cnt + RETRY_W'(1);
    end
  end

  // Channel index for sequential mode; a retry keeps the same channel.
  always_ff @(posedge i_clock or negedge i_nReset) begin
    if (!i_nReset) begin
      idx <= '0;
    end else if (restart) begin
      idx <= '0;
    end else if (seq_advance) begin
      idx <= idx + IDX_W'(1);
    end
  end

  // Fail mask: snapshot of outstanding channels on the way into ERROR.
  always_ff @(posedge i_clock or negedge i_nReset) begin
    if (!i_nReset) begin
      fail_mask <= '0;
    end else if (restart) begin
      fail_mask <= '0;
    end else if (do_fail) begin
      fail_mask <= ~seen;
    end
  end

  // Moore output decode from state and registered bookkeeping.
  always_comb begin
    status     = CODE_RESET;
    init_start = '0;
    running    = 1'b0;
    error      = 1'b0;
    unique case (state)
      ST_RESET: status = CODE_RESET;
      ST_INIT_START: begin
        status = CODE_INIT;
        // Parallel mode re-pulses only channels not yet latched as done.
        if (SEQUENTIAL != 0) init_start = NUM_PERIPH'(1) << idx;
        else                 init_start = ~done_latch;
      end
      ST_INIT_WAIT: status = CODE_INIT;
      ST_IDLE:      status = CODE_IDLE;
      ST_RUN: begin
        status  = CODE_RUN;
        running = 1'b1;
      end
      ST_ERROR: begin
        status = CODE_ERROR;
        error  = 1'b1;
      end
      default: status = CODE_RESET;
    endcase
  end

  assign bus.o_status     = status;
  assign bus.o_initStart  = init_start;
  assign bus.o_running    = running;
  assign bus.o_error      = error;
  assign bus.o_failMask   = fail_mask;
  assign bus.o_retryCount = retry_cnt;

endmodule

// File: tb/tb_iagc_init_seq_fsm.sv
// Self-checking bench for iagc_init_seq_fsm: one parallel-mode and one
// sequential-mode instance driven with identical inputs. Directed scenarios
// plus randomized done-timing checked against an attempt-level model.
module tb_iagc_init_seq_fsm;

  localparam int NP = 2;
  localparam int TO = 8;
  localparam int MR = 1;
  localparam int SS = 4;
  localparam int NEVER = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  // Expected per-cycle output word for each instance (0 = parallel, 1 = sequential).
  logic [10:0] exp_tr [2][64];

  always #5 clk = ~clk;

  iagc_init_seq_fsm_if #(.STATUS_SIZE(SS), .NUM_PERIPH(NP), .MAX_RETRIES(MR)) bus_p ();
  iagc_init_seq_fsm_if #(.STATUS_SIZE(SS), .NUM_PERIPH(NP), .MAX_RETRIES(MR)) bus_s ();

  iagc_init_seq_fsm #(
    .STATUS_SIZE(SS), .NUM_PERIPH(NP), .TIMEOUT_CYCLES(TO),
    .MAX_RETRIES(MR), .SEQUENTIAL(0)
  ) dut_p (
    .i_clock (clk),
    .i_nReset(rst_n),
    .bus     (bus_p)
  );

  iagc_init_seq_fsm #(
    .STATUS_SIZE(SS), .NUM_PERIPH(NP), .TIMEOUT_CYCLES(TO),
    .MAX_RETRIES(MR), .SEQUENTIAL(1)
  ) dut_s (
    .i_clock (clk),
    .i_nReset(rst_n),
    .bus     (bus_s)
  );

  // Output word: {status[3:0], initStart[1:0], running, error, failMask[1:0], retryCount}.
  function automatic logic [10:0] pack(input int st, input logic [1:0] pm, input logic run,
                                       input logic err, input logic [1:0] fm, input int rc);
    return {4'(st), pm, run, err, fm, 1'(rc)};
  endfunction

  function automatic logic [10:0] obs(input int m);
    if (m == 0)
      return {bus_p.o_status, bus_p.o_initStart, bus_p.o_running, bus_p.o_error,
              bus_p.o_failMask, bus_p.o_retryCount};
    return {bus_s.o_status, bus_s.o_initStart, bus_s.o_running, bus_s.o_error,
            bus_s.o_failMask, bus_s.o_retryCount};
  endfunction

  task automatic set_in(input logic [1:0] done, input logic start, input logic stop,
                        input logic clr);
    bus_p.i_initDone = done;  bus_s.i_initDone = done;
    bus_p.i_start = start;    bus_s.i_start = start;
    bus_p.i_stop = stop;      bus_s.i_stop = stop;
    bus_p.i_clearError = clr; bus_s.i_clearError = clr;
  endtask

  // Advance one cycle; outputs are read 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves both instances in RESET with reset just released (cycle -1).
  task automatic do_reset();
    set_in(2'b00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Attempt-level model: each attempt is one pulse cycle followed by up to TO
  // wait cycles. A channel is "seen" once its done level is high on a wait
  // cycle of the current sequence. d/e bound the cycles the done level is high.
  task automatic build_trace(input int m, input int d0, input int e0, input int d1, input int e1);
    int d[2];
    int e[2];
    bit seen[2];
    int s, retries, idx, fin_at, fin_status;
    bit att_over, complete;
    logic [1:0] pm, fm;
    d[0] = d0; e[0] = e0; d[1] = d1; e[1] = e1;
    seen[0] = 1'b0; seen[1] = 1'b0;
    s = 0; retries = 0; idx = 0; fin_at = -1; fin_status = 0; fm = 2'b00;
    while (fin_at < 0) begin
      for (int k = 0; k < NP; k++) pm[k] = (m == 1) ? (k == idx) : !seen[k];
      exp_tr[m][s] = pack(1, pm, 1'b0, 1'b0, 2'b00, retries);
      att_over = 1'b0;
      for (int c = s + 1; c <= s + TO && !att_over; c++) begin
        exp_tr[m][c] = pack(1, 2'b00, 1'b0, 1'b0, 2'b00, retries);
        for (int k = 0; k < NP; k++) if (c >= d[k] && c <= e[k]) seen[k] = 1'b1;
        complete = (m == 1) ? seen[idx] : (seen[0] && seen[1]);
        if (complete) begin
          att_over = 1'b1;
          if (m == 0 || idx == NP - 1) begin
            fin_at = c + 1; fin_status = 2;
          end else begin
            idx++; s = c + 1;
          end
        end else if (c == s + TO) begin
          att_over = 1'b1;
          if (retries < MR) begin
            retries++; s = c + 1;
          end else begin
            fin_at = c + 1; fin_status = 4; fm = {!seen[1], !seen[0]};
          end
        end
      end
    end
    for (int n = fin_at; n < 64; n++)
      exp_tr[m][n] = pack(fin_status, 2'b00, 1'b0, fin_status == 4, fm, retries);
  endtask

  // Release with both channels already done: RESET, INIT (pulse 11), INIT, IDLE.
  task automatic test_reset();
    logic [10:0] want;
    set_in(2'b11, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    for (int m = 0; m < 2; m++) begin
      total++;
      if (obs(m) !== 11'h000) begin
        bad++; $display("FAIL reset_held_m%0d: got %h want %h", m, obs(m), 11'h000);
      end
    end
    rst_n = 1'b1;
    for (int n = -1; n <= 2; n++) begin
      if (n >= 0) tick();
      case (n)
        -1:      want = pack(0, 2'b00, 0, 0, 2'b00, 0);
        0:       want = pack(1, 2'b11, 0, 0, 2'b00, 0);
        1:       want = pack(1, 2'b00, 0, 0, 2'b00, 0);
        default: want = pack(2, 2'b00, 0, 0, 2'b00, 0);
      endcase
      total++;
      if (obs(0) !== want) begin
        bad++; $display("FAIL reset_seq cyc%0d: got %h want %h", n, obs(0), want);
      end
    end
  endtask

  // ch0 done early, ch1 only after the first timeout: one retry pulsing ch1 only.
  task automatic test_parallel_retry();
    logic [10:0] want;
    do_reset();
    set_in(2'b01, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n <= 11; n++) begin
      tick();
      set_in((n >= 9) ? 2'b11 : 2'b01, 1'b0, 1'b0, 1'b0);
      if (n == 0)      want = pack(1, 2'b11, 0, 0, 2'b00, 0);
      else if (n <= 8) want = pack(1, 2'b00, 0, 0, 2'b00, 0);
      else if (n == 9) want = pack(1, 2'b10, 0, 0, 2'b00, 1);
      else if (n == 10) want = pack(1, 2'b00, 0, 0, 2'b00, 1);
      else             want = pack(2, 2'b00, 0, 0, 2'b00, 1);
      total++;
      if (obs(0) !== want) begin
        bad++; $display("FAIL par_retry cyc%0d: got %h want %h", n, obs(0), want);
      end
    end
  endtask

  // ch1 never done: two timeouts, ERROR with failMask 10, then clearError restarts.
  task automatic test_error_clear();
    logic [10:0] want;
    do_reset();
    set_in(2'b01, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n <= 21; n++) begin
      tick();
      // clearError during INIT_WAIT must be ignored; the second one leaves ERROR.
      set_in(2'b01, 1'b0, 1'b0, (n == 4) || (n == 19));
      if (n == 0)       want = pack(1, 2'b11, 0, 0, 2'b00, 0);
      else if (n <= 8)  want = pack(1, 2'b00, 0, 0, 2'b00, 0);
      else if (n == 9)  want = pack(1, 2'b10, 0, 0, 2'b00, 1);
      else if (n <= 17) want = pack(1, 2'b00, 0, 0, 2'b00, 1);
      else if (n <= 19) want = pack(4, 2'b00, 0, 1, 2'b10, 1);
      else if (n == 20) want = pack(1, 2'b11, 0, 0, 2'b00, 0);
      else              want = pack(1, 2'b00, 0, 0, 2'b00, 0);
      total++;
      if (obs(0) !== want) begin
        bad++; $display("FAIL err_clear cyc%0d: got %h want %h", n, obs(0), want);
      end
    end
  endtask

  // Sequential: ch0 done 3 cycles after its pulse, ch1 2 cycles after its pulse.
  task automatic test_sequential();
    logic [10:0] want;
    do_reset();
    for (int n = 0; n <= 8; n++) begin
      tick();
      set_in({n >= 6, n >= 3}, 1'b0, 1'b0, 1'b0);
      if (n == 0)      want = pack(1, 2'b01, 0, 0, 2'b00, 0);
      else if (n == 4) want = pack(1, 2'b10, 0, 0, 2'b00, 0);
      else if (n <= 6) want = pack(1, 2'b00, 0, 0, 2'b00, 0);
      else             want = pack(2, 2'b00, 0, 0, 2'b00, 0);
      total++;
      if (obs(1) !== want) begin
        bad++; $display("FAIL seq_order cyc%0d: got %h want %h", n, obs(1), want);
      end
    end
  endtask

  // IDLE/RUN handshake including start+stop together and ignored inputs in RUN.
  task automatic test_run_idle();
    logic [1:0] stim [6];
    int         want_st [6];
    logic [10:0] want;
    // stim = {start, stop}; want_st = status after the edge ending that cycle.
    stim[0] = 2'b11; want_st[0] = 2;
    stim[1] = 2'b01; want_st[1] = 2;
    stim[2] = 2'b10; want_st[2] = 3;
    stim[3] = 2'b10; want_st[3] = 3;
    stim[4] = 2'b11; want_st[4] = 2;
    stim[5] = 2'b10; want_st[5] = 3;
    do_reset();
    set_in(2'b11, 1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();
    total++;
    if (bus_p.o_status !== 4'd2) begin
      bad++; $display("FAIL run_idle_entry: got %0d want 2", bus_p.o_status);
    end
    for (int i = 0; i < 6; i++) begin
      // clearError rides along in RUN and must have no effect.
      set_in(2'b11, stim[i][1], stim[i][0], i == 3);
      tick();
      want = pack(want_st[i], 2'b00, want_st[i] == 3, 0, 2'b00, 0);
      total++;
      if (obs(0) !== want) begin
        bad++; $display("FAIL run_idle step%0d: got %h want %h", i, obs(0), want);
      end
    end
    set_in(2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset mid-INIT_WAIT of the retry attempt, then a clean restart.
  task automatic test_async_reset();
    logic [10:0] want;
    do_reset();
    for (int n = 0; n <= 10; n++) tick();
    want = pack(1, 2'b00, 0, 0, 2'b00, 1);
    total++;
    if (obs(0) !== want) begin
      bad++; $display("FAIL areset_pre: got %h want %h", obs(0), want);
    end
    #3;
    rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      total++;
      if (obs(m) !== 11'h000) begin
        bad++; $display("FAIL areset_zero_m%0d: got %h want %h", m, obs(m), 11'h000);
      end
    end
    tick();
    rst_n = 1'b1;
    set_in(2'b11, 1'b0, 1'b0, 1'b0);
    total++;
    if (obs(0) !== 11'h000) begin
      bad++; $display("FAIL areset_release: got %h want %h", obs(0), 11'h000);
    end
    tick();
    want = pack(1, 2'b11, 0, 0, 2'b00, 0);
    total++;
    if (obs(0) !== want) begin
      bad++; $display("FAIL areset_pulse: got %h want %h", obs(0), want);
    end
  endtask

  // Random done windows (levels, short pulses, or never) on both instances.
  task automatic test_random();
    int d[2];
    int e[2];
    logic [1:0] done;
    for (int sc = 0; sc < 30; sc++) begin
      for (int k = 0; k < NP; k++) begin
        if ($urandom_range(0, 4) == 0) d[k] = NEVER;
        else d[k] = $urandom_range(0, 25);
        e[k] = ($urandom_range(0, 2) == 0) ? d[k] + $urandom_range(0, 2) : NEVER;
      end
      build_trace(0, d[0], e[0], d[1], e[1]);
      build_trace(1, d[0], e[0], d[1], e[1]);
      do_reset();
      for (int n = 0; n < 40; n++) begin
        tick();
        for (int k = 0; k < NP; k++) done[k] = (n >= d[k]) && (n <= e[k]);
        set_in(done, 1'b0, 1'b0, 1'b0);
        for (int m = 0; m < 2; m++) begin
          total++;
          if (obs(m) !== exp_tr[m][n]) begin
            bad++;
            $display("FAIL rand sc%0d m%0d cyc%0d d=%0d/%0d e=%0d/%0d: got %h want %h",
                     sc, m, n, d[0], d[1], e[0], e[1], obs(m), exp_tr[m][n]);
          end
        end
      end
    end
  endtask

  initial begin
    set_in(2'b00, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_parallel_retry();
    test_error_clear();
    test_sequential();
    test_run_idle();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
